// File: rtl/multiboot_pkg.sv
// Shared ICAP command words, SPI opcodes, sequencer state encoding and the
// byte-wise bit-reversal helper used by the ICAP output register.
package multiboot_pkg;

  localparam logic [15:0] SYNC1     = 16'hAA99;
  localparam logic [15:0] SYNC2     = 16'h5566;
  localparam logic [15:0] WR_CMD    = 16'h30A1;
  localparam logic [15:0] CMD_NULL  = 16'h0000;
  localparam logic [15:0] WR_GEN1   = 16'h3261;
  localparam logic [15:0] WR_GEN2   = 16'h3281;
  localparam logic [15:0] WR_MODE   = 16'h3301;
  localparam logic [15:0] MODE_X4   = 16'h3100;
  localparam logic [15:0] CMD_IPROG = 16'h000E;
  localparam logic [15:0] NOOP      = 16'h2000;
  localparam logic [15:0] IDLE_WORD = 16'hFFFF;

  localparam logic [7:0] OP_X1 = 8'h03;
  localparam logic [7:0] OP_X4 = 8'h6B;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_SYNC = 3'd1,
    ST_HDR  = 3'd2,
    ST_GEN  = 3'd3,
    ST_MODE = 3'd4,
    ST_RBT  = 3'd5,
    ST_NOOP = 3'd6
  } state_e;

  // ICAP_SPARTAN6 expects each byte presented MSB-first on bit 0.
  function automatic logic [15:0] byte_rev(input logic [15:0] w);
    logic [15:0] r;
    for (int i = 0; i < 8; i++) begin
      r[7-i]  = w[i];
      r[15-i] = w[8+i];
    end
    return r;
  endfunction

endpackage

// File: rtl/multiboot_icap_seq_if.sv
// Request handshake, status flags and registered ICAP pins of the multiboot
// sequencer, bundled as one port.
interface multiboot_icap_seq_if;

  logic        req_valid;
  logic [3:0]  req_slot;
  logic        req_ready;
  logic        busy;
  logic        done;
  logic        err;
  logic        icap_ce_n;
  logic        icap_wr_n;
  logic [15:0] icap_i;

  modport master (
    output req_valid, req_slot,
    input  req_ready, busy, done, err, icap_ce_n, icap_wr_n, icap_i
  );

  modport slave (
    input  req_valid, req_slot,
    output req_ready, busy, done, err, icap_ce_n, icap_wr_n, icap_i
  );

endinterface

// File: rtl/multiboot_trig_filter.sv
// Button / legacy REBOOT line conditioner: 2-flop synchroniser, history shift
// register and a single-cycle trigger per accepted high-to-low transition.
module multiboot_trig_filter #(
  parameter int FILTER_LEN = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_btn,
  output logic o_trig
);

  logic [1:0]          r_sync;
  logic [FILTER_LEN:0] r_hist;
  logic                r_trig;
  logic                w_fire;

  // Oldest sample high followed by FILTER_LEN consecutive low samples.
  assign w_fire = r_hist[FILTER_LEN] && (r_hist[FILTER_LEN-1:0] == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= '0;
      r_hist <= '0;
      r_trig <= 1'b0;
    end else begin
      r_sync <= {r_sync[0], i_btn};
      r_hist <= {r_hist[FILTER_LEN-1:0], r_sync[1]};
      r_trig <= w_fire;
    end
  end

  assign o_trig = r_trig;

endmodule

// File: rtl/multiboot_icap_seq.sv
// Spartan-6 ICAP multiboot sequencer: accepts a slot request or a filtered
// button trigger and streams the warm-boot / IPROG command words to ICAP.
module multiboot_icap_seq
  import multiboot_pkg::*;
#(
  parameter int                     NUM_SLOTS    = 4,
  parameter logic [24*NUM_SLOTS-1:0] SLOT_ADDR   = {24'h210000, 24'h160000,
                                                    24'h0B0000, 24'h000000},
  parameter int                     DEFAULT_SLOT = 1,
  parameter int                     SPI_X4       = 1,
  parameter int                     NOOP_COUNT   = 4,
  parameter int                     FILTER_LEN   = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 reboot_btn,
  multiboot_icap_seq_if.slave  bus
);

  localparam logic [7:0] OP = (SPI_X4 != 0) ? OP_X4 : OP_X1;

  state_e      r_state, w_state_nxt;
  logic [3:0]  r_idx, w_idx_nxt, w_last;
  logic [23:0] r_addr;
  logic [23:0] w_tab [16];
  logic [3:0]  w_sel_slot;
  logic        w_trig, w_slot_ok, w_accept, w_start, w_bad, w_btn_go;
  logic [15:0] w_word;
  logic        w_active;

  logic        r_ce_n, r_wr_n, r_busy, r_done, r_err, r_ready;
  logic [15:0] r_icap;

  multiboot_trig_filter #(
    .FILTER_LEN (FILTER_LEN)
  ) u_filter (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_btn  (reboot_btn),
    .o_trig (w_trig)
  );

  // Full 16-entry table so any 4-bit slot index selects a defined entry.
  for (genvar k = 0; k < 16; k++) begin : g_tab
    if (k < NUM_SLOTS) begin : g_slot
      assign w_tab[k] = SLOT_ADDR[24*k +: 24];
    end else begin : g_pad
      assign w_tab[k] = '0;
    end
  end

  assign w_slot_ok  = {1'b0, bus.req_slot} < 5'(NUM_SLOTS);
  assign w_accept   = bus.req_valid && r_ready;
  assign w_start    = w_accept && w_slot_ok;
  assign w_bad      = w_accept && !w_slot_ok;
  assign w_btn_go   = w_trig && r_ready && !bus.req_valid;
  assign w_sel_slot = w_start ? bus.req_slot : 4'(DEFAULT_SLOT);

  always_ff @(posedge clk) begin
    if (w_start || w_btn_go) begin
      r_addr <= w_tab[w_sel_slot];
    end
  end

  // ---- state register ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_idx   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
    end
  end

  // ---- next-state logic: r_state/r_idx name the word currently on the pins ----
  always_comb begin
    w_last = 4'd0;
    case (r_state)
      ST_SYNC, ST_HDR, ST_MODE, ST_RBT: w_last = 4'd1;
      ST_GEN:                           w_last = 4'd3;
      ST_NOOP:                          w_last = 4'(NOOP_COUNT - 1);
      default:                          w_last = 4'd0;
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx + 4'd1;
    if (r_state != ST_IDLE && r_idx == w_last) begin
      w_idx_nxt = 4'd0;
    end
    case (r_state)
      ST_IDLE: begin
        w_idx_nxt = 4'd0;
        if (w_start || w_btn_go) w_state_nxt = ST_SYNC;
      end
      ST_SYNC: if (r_idx == w_last) w_state_nxt = ST_HDR;
      ST_HDR:  if (r_idx == w_last) w_state_nxt = ST_GEN;
      ST_GEN:  if (r_idx == w_last) w_state_nxt = (SPI_X4 != 0) ? ST_MODE : ST_RBT;
      ST_MODE: if (r_idx == w_last) w_state_nxt = ST_RBT;
      ST_RBT:  if (r_idx == w_last) w_state_nxt = ST_NOOP;
      ST_NOOP: if (r_idx == w_last) w_state_nxt = ST_IDLE;
      default: begin
        w_state_nxt = ST_IDLE;
        w_idx_nxt   = 4'd0;
      end
    endcase
  end

  // ---- output decode: word for the upcoming cycle, captured by the pin register ----
  always_comb begin
    w_word   = IDLE_WORD;
    w_active = 1'b1;
    case (w_state_nxt)
      ST_SYNC: w_word = w_idx_nxt[0] ? SYNC2 : SYNC1;
      ST_HDR:  w_word = w_idx_nxt[0] ? CMD_NULL : WR_CMD;
      ST_GEN: begin
        case (w_idx_nxt[1:0])
          2'd0:    w_word = WR_GEN1;
          2'd1:    w_word = r_addr[15:0];
          2'd2:    w_word = WR_GEN2;
          default: w_word = {OP, r_addr[23:16]};
        endcase
      end
      ST_MODE: w_word = w_idx_nxt[0] ? MODE_X4 : WR_MODE;
      ST_RBT:  w_word = w_idx_nxt[0] ? CMD_IPROG : WR_CMD;
      ST_NOOP: w_word = NOOP;
      default: begin
        w_word   = IDLE_WORD;
        w_active = 1'b0;
      end
    endcase
  end

  // ---- registered ICAP pins and status ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ce_n  <= 1'b1;
      r_wr_n  <= 1'b1;
      r_icap  <= IDLE_WORD;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
      r_ready <= 1'b0;
    end else begin
      r_ce_n  <= !w_active;
      r_wr_n  <= !w_active;
      r_icap  <= byte_rev(w_word);
      r_busy  <= w_active;
      r_done  <= (r_state == ST_NOOP) && (w_state_nxt == ST_IDLE);
      r_err   <= w_bad;
      r_ready <= (w_state_nxt == ST_IDLE);
    end
  end

  assign bus.icap_ce_n = r_ce_n;
  assign bus.icap_wr_n = r_wr_n;
  assign bus.icap_i    = r_icap;
  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
  assign bus.err       = r_err;
  assign bus.req_ready = r_ready;

endmodule
